// File: rtl/automata_stage_pipe.sv
// automata_stage_pipe
// Forwards the symbol stream and its stream-reset flag through a PIPE_DEPTH
// register pipeline, and collects this stage's automata report bits into a
// sticky vector plus a timestamped report FIFO drained over valid/ready.
// Optional feature macro: AUTOMATA_STAGE_FIRST_HIT_EN (first report cycle
// capture). When undefined, first_hit_valid/first_hit_cycle are tied to 0.
module automata_stage_pipe #(
  parameter int SYM_W       = 8,
  parameter int NUM_REPORTS = 16,
  parameter int PIPE_DEPTH  = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   sym_reset,
  input  logic [SYM_W-1:0]       in_symbols,
  input  logic [NUM_REPORTS-1:0] reports,
  input  logic                   clear_sticky,
  output logic [SYM_W-1:0]       out_symbols,
  output logic                   out_reset,
  output logic [NUM_REPORTS-1:0] sticky,
  output logic                   overflow,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [NUM_REPORTS-1:0] rpt_vec,
  output logic [CNT_W-1:0]       rpt_cycle,
  output logic                   first_hit_valid,
  output logic [CNT_W-1:0]       first_hit_cycle
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // ---------------------------------------------------------------------
  // Symbol / stream-reset pipeline
  // ---------------------------------------------------------------------
  logic [SYM_W-1:0] sym_pipe [PIPE_DEPTH];
  logic             rst_pipe [PIPE_DEPTH];

  // Shift symbol and reset bit together, only on run cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        sym_pipe[i] <= '0;
        rst_pipe[i] <= 1'b1;
      end
    end else if (run) begin
      sym_pipe[0] <= in_symbols;
      rst_pipe[0] <= sym_reset;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        sym_pipe[i] <= sym_pipe[i-1];
        rst_pipe[i] <= rst_pipe[i-1];
      end
    end
  end

  assign out_symbols = sym_pipe[PIPE_DEPTH-1];
  assign out_reset   = rst_pipe[PIPE_DEPTH-1];

  // ---------------------------------------------------------------------
  // Run-cycle counter
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;

  // Count run cycles; a stream reset on a run cycle restarts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (run) begin
      if (sym_reset) cnt <= '0;
      else           cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Report FIFO
  // ---------------------------------------------------------------------
  logic [NUM_REPORTS-1:0] mem_vec   [FIFO_DEPTH];
  logic [CNT_W-1:0]       mem_cycle [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic                   full;
  logic                   rpt_event;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Event/handshake decode. Full is count's MSB since FIFO_DEPTH is a
  // power of two; a pop in the same cycle frees a slot for the push.
  always_comb begin
    rpt_event = run && (reports != '0);
    full      = (count == (AW+1)'(FIFO_DEPTH));
    pop       = rpt_valid && rpt_ready;
    push      = rpt_event && (!full || pop);
    drop      = rpt_event && full && !pop;
  end

  // Storage array; no reset needed because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_vec[wr_ptr]   <= reports;
      mem_cycle[wr_ptr] <= cnt;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at AW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head entry presentation; reads zero whenever the FIFO is empty.
  always_comb begin
    rpt_valid = (count != '0);
    rpt_vec   = '0;
    rpt_cycle = '0;
    if (rpt_valid) begin
      rpt_vec   = mem_vec[rd_ptr];
      rpt_cycle = mem_cycle[rd_ptr];
    end
  end

  // ---------------------------------------------------------------------
  // Sticky report vector and overflow flag
  // ---------------------------------------------------------------------

  // Accumulate reports; a same-cycle report survives a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
    end else if (clear_sticky) begin
      sticky <= run ? reports : '0;
    end else if (run) begin
      sticky <= sticky | reports;
    end
  end

  // Overflow is set by a dropped push, which takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_sticky) begin
      overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // First-hit capture
  // ---------------------------------------------------------------------
`ifdef AUTOMATA_STAGE_FIRST_HIT_EN
  logic             fh_valid;
  logic [CNT_W-1:0] fh_cycle;

  // Latch the cycle of the first event after reset/clear; a clear with a
  // same-cycle event re-arms and captures that event immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fh_valid <= 1'b0;
      fh_cycle <= '0;
    end else if (clear_sticky) begin
      fh_valid <= rpt_event;
      fh_cycle <= rpt_event ? cnt : '0;
    end else if (rpt_event && !fh_valid) begin
      fh_valid <= 1'b1;
      fh_cycle <= cnt;
    end
  end

  assign first_hit_valid = fh_valid;
  assign first_hit_cycle = fh_cycle;
`else
  assign first_hit_valid = 1'b0;
  assign first_hit_cycle = '0;
`endif

endmodule

// File: tb/tb_automata_stage_pipe.sv
// Directed self-checking bench for automata_stage_pipe
// (PIPE_DEPTH=2, FIFO_DEPTH=4, CNT_W=4). First-hit expectations follow
// AUTOMATA_STAGE_FIRST_HIT_EN.
module tb_automata_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        sym_reset;
  logic [7:0]  in_symbols;
  logic [15:0] reports;
  logic        clear_sticky;
  logic [7:0]  out_symbols;
  logic        out_reset;
  logic [15:0] sticky;
  logic        overflow;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [15:0] rpt_vec;
  logic [3:0]  rpt_cycle;
  logic        first_hit_valid;
  logic [3:0]  first_hit_cycle;

  int checks   = 0;
  int failures = 0;

  automata_stage_pipe #(
    .SYM_W(8), .NUM_REPORTS(16), .PIPE_DEPTH(2), .FIFO_DEPTH(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .sym_reset(sym_reset),
    .in_symbols(in_symbols), .reports(reports), .clear_sticky(clear_sticky),
    .out_symbols(out_symbols), .out_reset(out_reset), .sticky(sticky),
    .overflow(overflow), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_vec(rpt_vec), .rpt_cycle(rpt_cycle),
    .first_hit_valid(first_hit_valid), .first_hit_cycle(first_hit_cycle)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; sym_reset = 1'b0; in_symbols = '0;
    reports = '0; clear_sticky = 1'b0; rpt_ready = 1'b0;
    repeat (2) tick();

    // Reset values
    check_eq("rst_out_symbols", 32'(out_symbols), 32'h0);
    check_eq("rst_out_reset",   32'(out_reset),   32'h1);
    check_eq("rst_sticky",      32'(sticky),      32'h0);
    check_eq("rst_overflow",    32'(overflow),    32'h0);
    check_eq("rst_rpt_valid",   32'(rpt_valid),   32'h0);
    check_eq("rst_rpt_vec",     32'(rpt_vec),     32'h0);
    check_eq("rst_rpt_cycle",   32'(rpt_cycle),   32'h0);
    check_eq("rst_fh_valid",    32'(first_hit_valid), 32'h0);
    check_eq("rst_fh_cycle",    32'(first_hit_cycle), 32'h0);
    rst_n = 1'b1;

    // Pipeline hold with run toggling 1,0,1
    in_symbols = 8'h11; run = 1'b1; tick();          // cnt=1
    check_eq("pipe_r1_sym", 32'(out_symbols), 32'h00);
    check_eq("pipe_r1_rst", 32'(out_reset),   32'h1);
    in_symbols = 8'h22; run = 1'b0; tick();
    check_eq("pipe_hold_sym", 32'(out_symbols), 32'h00);
    check_eq("pipe_hold_rst", 32'(out_reset),   32'h1);
    run = 1'b1; tick();                              // cnt=2
    check_eq("pipe_r2_sym", 32'(out_symbols), 32'h11);
    check_eq("pipe_r2_rst", 32'(out_reset),   32'h0);
    run = 1'b0; tick();
    check_eq("pipe_hold2_sym", 32'(out_symbols), 32'h11);

    // Stream reset travels with the same two-run lag; counter restarts
    run = 1'b1; sym_reset = 1'b1; tick();            // cnt=0
    check_eq("srst_lag0", 32'(out_reset), 32'h0);
    sym_reset = 1'b0; tick();                        // cnt=1
    check_eq("srst_lag2", 32'(out_reset), 32'h1);
    repeat (4) tick();                               // cnt=5
    check_eq("srst_clear", 32'(out_reset), 32'h0);

    // Timestamp: event at run cycle 5, held until ready
    check_eq("ts_empty_before", 32'(rpt_valid), 32'h0);
    reports = 16'h0001; tick();                      // push (1,5), cnt=6
    check_eq("ts_valid", 32'(rpt_valid), 32'h1);
    check_eq("ts_vec",   32'(rpt_vec),   32'h0001);
    check_eq("ts_cycle", 32'(rpt_cycle), 32'h5);
    reports = '0; run = 1'b0; tick();
    check_eq("ts_hold_vec",   32'(rpt_vec),   32'h0001);
    check_eq("ts_hold_cycle", 32'(rpt_cycle), 32'h5);
    rpt_ready = 1'b1; tick();
    check_eq("ts_popped", 32'(rpt_valid), 32'h0);
    rpt_ready = 1'b0;
    check_eq("ts_sticky", 32'(sticky), 32'h0001);

    // Overflow: five events with no pop; cycles 6..9 kept, 10 dropped
    run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      reports = 16'(k + 1);
      tick();
      if (k == 3) check_eq("ovf_not_yet", 32'(overflow), 32'h0);
    end
    run = 1'b0; reports = '0;                        // cnt=11
    check_eq("ovf_set", 32'(overflow), 32'h1);
    rpt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("ovf_drain_valid", 32'(rpt_valid), 32'h1);
      check_eq("ovf_drain_vec",   32'(rpt_vec),   32'(k + 1));
      check_eq("ovf_drain_cycle", 32'(rpt_cycle), 32'(6 + k));
      tick();
    end
    check_eq("ovf_drain_empty", 32'(rpt_valid), 32'h0);
    rpt_ready = 1'b0;
    check_eq("ovf_sticky", 32'(sticky), 32'h0007);
    clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
    check_eq("clr_sticky", 32'(sticky),   32'h0);
    check_eq("clr_ovf",    32'(overflow), 32'h0);

    // Full FIFO with same-cycle pop: cycles 11..14, then 15 with pop
    run = 1'b1; reports = 16'h0008;
    repeat (4) tick();
    rpt_ready = 1'b1; tick();                        // pop 11, push 15, cnt wraps to 0
    rpt_ready = 1'b0; run = 1'b0; reports = '0;
    check_eq("fullpop_ovf",  32'(overflow),  32'h0);
    check_eq("fullpop_head", 32'(rpt_cycle), 32'hC);
    rpt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("fullpop_drain_cycle", 32'(rpt_cycle), 32'(12 + k));
      tick();
    end
    check_eq("fullpop_empty", 32'(rpt_valid), 32'h0);
    rpt_ready = 1'b0;

    // Counter wrap: 17 run cycles after a stream reset -> tag 1
    run = 1'b1; sym_reset = 1'b1; tick(); sym_reset = 1'b0;
    repeat (17) tick();
    reports = 16'h0020; tick(); reports = '0; run = 1'b0;
    check_eq("wrap_cycle", 32'(rpt_cycle), 32'h1);
    rpt_ready = 1'b1; tick(); rpt_ready = 1'b0;
    // Stream reset then event -> tag 0
    run = 1'b1; sym_reset = 1'b1; tick(); sym_reset = 1'b0;
    reports = 16'h0004; tick(); reports = '0; run = 1'b0;
    check_eq("srst_tag_vec",   32'(rpt_vec),   32'h0004);
    check_eq("srst_tag_cycle", 32'(rpt_cycle), 32'h0);
    rpt_ready = 1'b1; tick(); rpt_ready = 1'b0;

    // Sticky/clear race
    clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
    run = 1'b1; reports = 16'h0100; tick();
    check_eq("race_pre", 32'(sticky), 32'h0100);
    clear_sticky = 1'b1; reports = 16'h0002; tick();
    clear_sticky = 1'b0; reports = '0; run = 1'b0;
    check_eq("race_sticky", 32'(sticky), 32'h0002);
    rpt_ready = 1'b1; repeat (2) tick(); rpt_ready = 1'b0;
    check_eq("race_drained", 32'(rpt_valid), 32'h0);

    // First hit: events at 3 and 7, then clear and event at 9
    clear_sticky = 1'b1; run = 1'b1; sym_reset = 1'b1; tick();
    clear_sticky = 1'b0; sym_reset = 1'b0;           // cnt=0
    repeat (3) tick();                               // cnt=3
    reports = 16'h0001; tick(); reports = '0;        // event @3
    repeat (3) tick();                               // cnt=7
    reports = 16'h0001; tick(); reports = '0;        // event @7, cnt=8
    run = 1'b0;
`ifdef AUTOMATA_STAGE_FIRST_HIT_EN
    check_eq("fh_valid_a", 32'(first_hit_valid), 32'h1);
    check_eq("fh_cycle_a", 32'(first_hit_cycle), 32'h3);
`else
    check_eq("fh_valid_a", 32'(first_hit_valid), 32'h0);
    check_eq("fh_cycle_a", 32'(first_hit_cycle), 32'h0);
`endif
    clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
    check_eq("fh_cleared", 32'(first_hit_valid), 32'h0);
    run = 1'b1; tick();                              // cnt=9
    reports = 16'h0001; tick(); reports = '0; run = 1'b0;
`ifdef AUTOMATA_STAGE_FIRST_HIT_EN
    check_eq("fh_valid_b", 32'(first_hit_valid), 32'h1);
    check_eq("fh_cycle_b", 32'(first_hit_cycle), 32'h9);
`else
    check_eq("fh_valid_b", 32'(first_hit_valid), 32'h0);
    check_eq("fh_cycle_b", 32'(first_hit_cycle), 32'h0);
`endif

    // Mid-stream asynchronous reset pulse
    check_eq("pre_rst_valid", 32'(rpt_valid), 32'h1);
    check_eq("pre_rst_out_reset", 32'(out_reset), 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_eq("async_rst_valid",     32'(rpt_valid), 32'h0);
    check_eq("async_rst_out_reset", 32'(out_reset), 32'h1);
    check_eq("async_rst_sticky",    32'(sticky),    32'h0);
    tick();
    rst_n = 1'b1;
    run = 1'b1; reports = 16'h0040; tick(); reports = '0; run = 1'b0;
    check_eq("post_rst_vec",   32'(rpt_vec),   32'h0040);
    check_eq("post_rst_cycle", 32'(rpt_cycle), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/automata_stage_pipe.md
# automata_stage_pipe

Parametrised successor to the per-group automata stage wrapper in the LTL monitor chain. Forwards the input symbol stream and its stream-reset flag through a configurable-depth register pipeline to the next stage. Aggregates the report bits of the automata driven by this stage into a sticky vector and a timestamped report FIFO, drained over a valid/ready handshake by the monitor's report collector.

## Interface
Parameters:
- `SYM_W`, 8: symbol width.
- `NUM_REPORTS`, 16: report bits collected from this stage's automata.
- `PIPE_DEPTH`, 1: symbol pipeline registers, ≥1.
- `FIFO_DEPTH`, 4: report FIFO entries, power of two, ≥2.
- `CNT_W`, 16: run-cycle counter width.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `run` in 1: stream-advance enable.
- `sym_reset` in 1: stream reset accompanying `in_symbols`.
- `in_symbols` in `SYM_W`: symbol presented to this stage's automata.
- `reports` in `NUM_REPORTS`: automata report outputs for the current symbol.
- `clear_sticky` in 1: clears `sticky`, `overflow` and first-hit state.
- `out_symbols` out `SYM_W`: delayed symbol to next stage.
- `out_reset` out 1: delayed stream reset to next stage.
- `sticky` out `NUM_REPORTS`: OR of all reports since last clear.
- `overflow` out 1: sticky; a report event was dropped on a full FIFO.
- `rpt_valid` out 1, `rpt_ready` in 1: report FIFO handshake.
- `rpt_vec` out `NUM_REPORTS`, `rpt_cycle` out `CNT_W`: head entry.
- `first_hit_valid` out 1, `first_hit_cycle` out `CNT_W`: see Configuration.

## Operation
- Reset (`rst_n`=0) values: all pipeline registers and `out_symbols`=0, `out_reset`=1, counter=0, `sticky`=0, `overflow`=0, FIFO empty (`rpt_valid`=0, `rpt_vec`=0, `rpt_cycle`=0), `first_hit_valid`=0, `first_hit_cycle`=0.
- Symbol pipeline: every stage, including the reset bit, advances only when `run`=1. With `run`=0 the whole pipeline holds, symbol and reset together.
- Run counter: `run`=1 increments it, wrapping from 2^CNT_W−1 to 0. `run`=1 with `sym_reset`=1 loads 0 instead.
- Report event: `run`=1 and `reports`≠0. Pushes {`reports`, counter value before this cycle's update}.
- FIFO rules:
  - Pop occurs when `rpt_valid` and `rpt_ready` are both 1.
  - Push while full without a same-cycle pop: entry dropped, `overflow` set.
  - Push while full with a same-cycle pop: entry accepted, no overflow.
  - Pop on empty: no effect.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - FIFO contents are unaffected by `sym_reset` and `clear_sticky`.
- Sticky: on `run`=1, `sticky` ← `sticky` | `reports`.
  - `clear_sticky`=1 loads `reports` if `run`=1, else 0. A same-cycle report wins over the clear.
  - `clear_sticky` clears `overflow`. A same-cycle overflow event still sets it.
- `reports` is ignored when `run`=0.

## Timing
- `out_symbols`/`out_reset` lag the input by exactly `PIPE_DEPTH` run cycles.
- No FIFO fall-through: a push in cycle N gives `rpt_valid`=1 in N+1 at the earliest.
- `rpt_vec` and `rpt_cycle` are stable while `rpt_valid`=1 and `rpt_ready`=0.
- `sticky` and `overflow` update one cycle after the causing event.
- `rst_n` assertion mid-operation clears everything immediately. The first push after deassertion carries cycle 0.

## Configuration
- `AUTOMATA_STAGE_FIRST_HIT_EN` defined:
  - The first report event after reset or `clear_sticky` latches its cycle into `first_hit_cycle` and sets `first_hit_valid`.
  - Later events do not update it until the next clear. A report in the same cycle as the clear re-arms and captures.
- Not defined: `first_hit_valid` and `first_hit_cycle` are tied to 0 and no capture logic exists.

## Test plan
- Pipeline hold: PIPE_DEPTH=2, symbols 0x11,0x22 with `run` toggling 1,0,1 -> `out_symbols`=0x11 after the second run cycle; `out_reset` tracks `sym_reset` with the same lag and freezes while `run`=0.
- Timestamp: `reports`=0x0001 at run cycle 5 with `rpt_ready`=0 -> `rpt_valid`=1 next cycle, `rpt_vec`=0x0001, `rpt_cycle`=5, held until `rpt_ready`=1.
- Overflow: FIFO_DEPTH=4, 5 events with `rpt_ready`=0 -> 4 entries kept, `overflow`=1. Repeat with a pop on the 5th push -> all accepted, `overflow`=0.
- Sticky/clear race: `reports`=0x0100, then `clear_sticky` together with `reports`=0x0002 -> `sticky`=0x0002.
- Counter wrap/reset: CNT_W=4, 17 run cycles -> counter=1. `sym_reset` with run -> next event tagged 0. Mid-stream `rst_n` pulse -> FIFO empty, `out_reset`=1.
- With the macro: events at cycles 3 and 7 -> `first_hit_cycle`=3; after `clear_sticky`, an event at cycle 9 -> 9. Without the macro -> both outputs 0.
